// File: rtl/ram_ctrl_pkg.sv
// Shared state encoding and default geometry for the ram_ctrl SRAM strobe sequencer.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF      = 16;
  localparam int DATA_W_DEF      = 8;
  localparam int WAIT_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    VSTROBE,
    VHOLD
  } state_t;

endpackage

// File: rtl/ram_ctrl_waitcnt.sv
// Strobe-width timer: loadable down-counter that loads WAIT_CYCLES-1 and flags done at zero.
module ram_ctrl_waitcnt #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset_bar,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int            CW       = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/ram_ctrl.sv
// Sequencer turning single-cycle requests into set-up/strobe/hold cycles for an async 64Kx8 SRAM.
// Define RAM_CTRL_WRITE_VERIFY_EN to add a read-back check after every write (rsp_err).
//
// state   | meaning
// IDLE    | req_ready high, waiting for a request
// SETUP   | address/data on the bus, strobes high
// STROBE  | cs_bar low plus we_bar (write) or oe_bar (read) for WAIT_CYCLES
// HOLD    | strobes high, address/data still held
// VSTROBE | verify read of the written location (cs_bar/oe_bar low)
// VHOLD   | strobes high, read-back compared with written data
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset_bar,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_indata,
  output logic              ram_cs_bar,
  output logic              ram_we_bar,
  output logic              ram_oe_bar,
  input  logic [DATA_W-1:0] ram_outdata
);

  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("ram_ctrl: WAIT_CYCLES must be >= 1");
  end

  state_t state_q, state_d;
  logic   we_q;
  logic   accept;
  logic   cnt_load, cnt_en, cnt_done;
  logic   cs_d, we_d, oe_d, ready_d, valid_d;

  assign accept = req_valid && req_ready;

  ram_ctrl_waitcnt #(.WAIT_CYCLES(WAIT_CYCLES)) u_waitcnt (
    .clk       (clk),
    .reset_bar (reset_bar),
    .load      (cnt_load),
    .en        (cnt_en),
    .done      (cnt_done)
  );

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  if (cnt_done) state_d = HOLD;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
      HOLD:    state_d = we_q ? VSTROBE : IDLE;
      VSTROBE: if (cnt_done) state_d = VHOLD;
      VHOLD:   state_d = IDLE;
`else
      HOLD:    state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered strobes line up with the state.
  always_comb begin
    cs_d     = !((state_d == STROBE) || (state_d == VSTROBE));
    we_d     = !((state_d == STROBE) && we_q);
    oe_d     = !(((state_d == STROBE) && !we_q) || (state_d == VSTROBE));
    ready_d  = (state_d == IDLE);
    valid_d  = (state_d == IDLE) && ((state_q == HOLD) || (state_q == VHOLD));
    cnt_load = (state_d != state_q) && ((state_d == STROBE) || (state_d == VSTROBE));
    cnt_en   = (state_q == STROBE) || (state_q == VSTROBE);
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      ram_cs_bar <= 1'b1;
      ram_we_bar <= 1'b1;
      ram_oe_bar <= 1'b1;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      ram_addr   <= '0;
      ram_indata <= '0;
      we_q       <= 1'b0;
    end else begin
      ram_cs_bar <= cs_d;
      ram_we_bar <= we_d;
      ram_oe_bar <= oe_d;
      req_ready  <= ready_d;
      rsp_valid  <= valid_d;
      if (accept) begin
        we_q       <= req_we;
        ram_addr   <= req_addr;
        ram_indata <= req_wdata;
      end
      if ((state_q == STROBE) && cnt_done && !we_q) begin
        rsp_rdata <= ram_outdata;
      end
    end
  end

`ifdef RAM_CTRL_WRITE_VERIFY_EN
  logic [DATA_W-1:0] vdata_q;

  // ram_indata still holds the written byte, so it doubles as the compare reference.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      vdata_q <= '0;
      rsp_err <= 1'b0;
    end else begin
      if ((state_q == VSTROBE) && cnt_done) begin
        vdata_q <= ram_outdata;
      end
      if (valid_d) begin
        rsp_err <= (state_q == VHOLD) && (vdata_q != ram_indata);
      end
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule
